regfile_arbiter: RTL

- Round-robin arbiter and sequencer that shares one single-port rank register file between up to NUM_REQ requesters, e.g. the host loader, the PageRank compute engine and the convergence checker.
- Each cycle it selects one requester and drives that requester's read or write onto the register-file control signals.
- It routes the one-cycle-late read data back to the requester that issued the read.
- A lock lets a requester hold the register file for read-modify-write sequences; a hold counter prevents starvation.

---
 rtl/regfile_arbiter_if.sv | 26 ++
 rtl/regfile_arbiter.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/regfile_arbiter_if.sv
// Requester-side bus of the register-file arbiter: per-requester request
// vectors in, one-hot grant and read response out.
interface regfile_arbiter_if #(
    parameter int NUM_REQ  = 4,
    parameter int WIDTH    = 21,
    parameter int ADDWIDTH = 5
);
    logic [NUM_REQ-1:0]          req;
    logic [NUM_REQ-1:0]          req_we;
    logic [NUM_REQ-1:0]          req_lock;
    logic [NUM_REQ*ADDWIDTH-1:0] req_addr;
    logic [NUM_REQ*WIDTH-1:0]    req_wdata;
    logic [NUM_REQ-1:0]          gnt;
    logic [NUM_REQ-1:0]          rsp_valid;
    logic [WIDTH-1:0]            rsp_data;

    modport master (
        output req, req_we, req_lock, req_addr, req_wdata,
        input  gnt, rsp_valid, rsp_data
    );

    modport slave (
        input  req, req_we, req_lock, req_addr, req_wdata,
        output gnt, rsp_valid, rsp_data
    );
endinterface

// File: rtl/regfile_arbiter.sv
// Round-robin arbiter sharing one single-port register file between NUM_REQ
// requesters, with an optional bounded lock for read-modify-write sequences.
module regfile_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int WIDTH    = 21,
    parameter int ADDWIDTH = 5,
    parameter int MAX_LOCK = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    regfile_arbiter_if.slave            bus,
    output logic                        rf_writeEnable,
    output logic                        rf_readEnable,
    output logic [ADDWIDTH-1:0]         rf_dest,
    output logic [ADDWIDTH-1:0]         rf_source,
    output logic [WIDTH-1:0]            rf_dataIn,
    input  logic [WIDTH-1:0]            rf_dataOut,
    output logic [$clog2(NUM_REQ)-1:0]  dbg_rr_ptr,
    output logic                        dbg_locked
);
    localparam int PW = $clog2(NUM_REQ);
    localparam int CW = $clog2(MAX_LOCK + 1);

    logic [PW-1:0]      rr_ptr;
    logic               locked;
    logic [PW-1:0]      lock_owner;
    logic [CW-1:0]      lock_cnt;
    logic [NUM_REQ-1:0] rsp_valid_q;

    logic               owner_hold;
    logic               found;
    logic [PW-1:0]      sel;
    logic [PW:0]        scan;
    logic [ADDWIDTH-1:0] sel_addr;
    logic [WIDTH-1:0]   sel_wdata;
    logic               sel_we;
    logic               sel_lock;
    logic [NUM_REQ-1:0] gnt_c;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(NUM_REQ - 1)) ? '0 : p + 1'b1;
    endfunction

    // Handshake: req[i] is the requester's valid, gnt[i] is the arbiter's
    // ready (combinational, same cycle); an access is accepted on any cycle
    // with req[i] && gnt[i], and the op/addr/data must be stable that cycle.
    assign owner_hold = locked && bus.req[lock_owner];

    always_comb begin
        found = 1'b0;
        sel   = '0;
        scan  = '0;
        if (owner_hold) begin
            found = 1'b1;
            sel   = lock_owner;
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                scan = {1'b0, rr_ptr} + (PW+1)'(k);
                if (scan >= (PW+1)'(NUM_REQ)) scan = scan - (PW+1)'(NUM_REQ);
                if (!found && bus.req[scan[PW-1:0]]) begin
                    found = 1'b1;
                    sel   = scan[PW-1:0];
                end
            end
        end
    end

    always_comb begin
        sel_addr       = '0;
        sel_wdata      = '0;
        sel_we         = 1'b0;
        sel_lock       = 1'b0;
        gnt_c          = '0;
        rf_writeEnable = 1'b0;
        rf_readEnable  = 1'b0;
        rf_dest        = '0;
        rf_source      = '0;
        rf_dataIn      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (sel == PW'(i)) begin
                sel_addr  = bus.req_addr[i*ADDWIDTH +: ADDWIDTH];
                sel_wdata = bus.req_wdata[i*WIDTH +: WIDTH];
                sel_we    = bus.req_we[i];
                sel_lock  = bus.req_lock[i];
            end
        end
        if (found) begin
            gnt_c[sel] = 1'b1;
            if (sel_we) begin
                rf_writeEnable = 1'b1;
                rf_dest        = sel_addr;
                rf_dataIn      = sel_wdata;
            end else begin
                rf_readEnable  = 1'b1;
                rf_source      = sel_addr;
            end
        end
    end

    assign bus.gnt       = gnt_c;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rf_dataOut;
    assign dbg_rr_ptr    = rr_ptr;
    assign dbg_locked    = locked;

    // lock_cnt counts grants already given under the lock, so the owner's
    // MAX_LOCK-th consecutive grant is its last. When the owner drops req,
    // the release pointer applies unless the same cycle's normal grant
    // advances it further.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr      <= '0;
            locked      <= 1'b0;
            lock_owner  <= '0;
            lock_cnt    <= '0;
            rsp_valid_q <= '0;
        end else begin
            rsp_valid_q <= (found && !sel_we) ? gnt_c : '0;
            if (owner_hold) begin
                if (!sel_lock || lock_cnt >= CW'(MAX_LOCK - 1)) begin
                    locked   <= 1'b0;
                    lock_cnt <= '0;
                    rr_ptr   <= next_ptr(lock_owner);
                end else begin
                    lock_cnt <= lock_cnt + 1'b1;
                end
            end else begin
                if (locked) begin
                    locked   <= 1'b0;
                    lock_cnt <= '0;
                    rr_ptr   <= next_ptr(lock_owner);
                end
                if (found) begin
                    if (sel_lock) begin
                        locked     <= 1'b1;
                        lock_owner <= sel;
                        lock_cnt   <= CW'(1);
                    end else begin
                        rr_ptr     <= next_ptr(sel);
                    end
                end
            end
        end
    end
endmodule
